// File: rtl/anton_neopixel_frame_sequencer_if.sv
// Command/config/status bundle between the APB register block, the frame
// sequencer and the NeoPixel stream logic.
interface anton_neopixel_frame_sequencer_if #(
    parameter int FRAME_BITS = 8
) ();
    logic                  cmdStart;
    logic                  cmdStop;
    logic                  cmdAbort;
    logic                  cfgLoop;
    logic [FRAME_BITS-1:0] cfgFrameLimit;
    logic                  irqClear;
    logic                  streamPixelOf;
    logic                  streamSyncOf;
    logic                  initSlowDone;
    logic                  regCtrlInit;
    logic                  regCtrlRun;
    logic                  initSlow;
    logic                  busy;
    logic                  frameDone;
    logic [FRAME_BITS-1:0] frameCount;
    logic                  irq;
    logic                  errTimeout;
    logic [2:0]            seqState;

    // The sequencer itself.
    modport slave (
        input  cmdStart, cmdStop, cmdAbort, cfgLoop, cfgFrameLimit, irqClear,
               streamPixelOf, streamSyncOf, initSlowDone,
        output regCtrlInit, regCtrlRun, initSlow, busy, frameDone, frameCount,
               irq, errTimeout, seqState
    );

    // Register block plus stream logic, seen as one environment.
    modport master (
        output cmdStart, cmdStop, cmdAbort, cfgLoop, cfgFrameLimit, irqClear,
               streamPixelOf, streamSyncOf, initSlowDone,
        input  regCtrlInit, regCtrlRun, initSlow, busy, frameDone, frameCount,
               irq, errTimeout, seqState
    );
endinterface

// File: rtl/anton_neopixel_frame_sequencer.sv
// Frame sequencer: slow-init handshake, per-frame stop/loop decision and
// frame counting for the NeoPixel stream logic. All outputs are registered.
module anton_neopixel_frame_sequencer #(
    parameter int INIT_TIMEOUT = 16,
    parameter int FRAME_BITS   = 8
) (
    input  logic                                  clk6_4mhz,
    input  logic                                  resetn,
    anton_neopixel_frame_sequencer_if.slave       bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INIT      = 3'd1,
        S_WAIT_INIT = 3'd2,
        S_STREAM    = 3'd3,
        S_GAP       = 3'd4
    } state_t;

    state_t                r_state;
    logic                  r_reg_ctrl_init;
    logic                  r_reg_ctrl_run;
    logic                  r_init_slow;
    logic                  r_busy;
    logic                  r_frame_done;
    logic [FRAME_BITS-1:0] r_frame_count;
    logic                  r_irq;
    logic                  r_err_timeout;
    logic                  r_stop_pending;
    logic [7:0]            r_init_timer;

    state_t                w_next_state;
    logic                  w_start;
    logic                  w_frame_inc;
    logic                  w_set_irq;
    logic                  w_set_err;
    logic                  w_stop_cond;
    logic [FRAME_BITS-1:0] w_count_inc;
    logic [7:0]            w_timer_dec;

    assign w_count_inc = (r_frame_count == {FRAME_BITS{1'b1}}) ? r_frame_count
                                                                : r_frame_count + 1'b1;
    assign w_timer_dec = r_init_timer - 8'd1;

    // A stop arriving together with the sync still ends this frame.
    assign w_stop_cond = !bus.cfgLoop || r_stop_pending || bus.cmdStop ||
                         ((bus.cfgFrameLimit != '0) && (w_count_inc == bus.cfgFrameLimit));

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_frame_inc  = 1'b0;
        w_set_irq    = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.cmdStart) begin
                    w_next_state = S_INIT;
                    w_start      = 1'b1;
                end
            end
            S_INIT: w_next_state = S_WAIT_INIT;
            S_WAIT_INIT: begin
                if (bus.initSlowDone) begin
                    w_next_state = S_STREAM;
                end else if (w_timer_dec == 8'd0) begin
                    w_next_state = S_IDLE;
                    w_set_err    = 1'b1;
                    w_set_irq    = 1'b1;
                end
            end
            S_STREAM: begin
                if (bus.streamPixelOf) begin
                    w_next_state = S_GAP;
                end
            end
            S_GAP: begin
                if (bus.streamSyncOf) begin
                    w_frame_inc = 1'b1;
                    if (w_stop_cond) begin
                        w_next_state = S_IDLE;
                        w_set_irq    = 1'b1;
                    end else begin
                        w_next_state = S_STREAM;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase

        // Abort outranks every frame/handshake event.
        if (bus.cmdAbort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
            w_frame_inc  = 1'b0;
            w_set_irq    = 1'b0;
            w_set_err    = 1'b0;
        end
    end

    always_ff @(posedge clk6_4mhz) begin
        if (!resetn) begin
            r_state         <= S_IDLE;
            r_reg_ctrl_init <= 1'b1;
            r_reg_ctrl_run  <= 1'b0;
            r_init_slow     <= 1'b0;
            r_busy          <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_count   <= '0;
            r_irq           <= 1'b0;
            r_err_timeout   <= 1'b0;
            r_stop_pending  <= 1'b0;
            r_init_timer    <= 8'd0;
        end else begin
            r_state         <= w_next_state;
            r_reg_ctrl_init <= (w_next_state == S_IDLE) || (w_next_state == S_INIT) ||
                               (w_next_state == S_WAIT_INIT);
            r_reg_ctrl_run  <= (w_next_state == S_STREAM) || (w_next_state == S_GAP);
            r_init_slow     <= (w_next_state == S_INIT);
            r_busy          <= (w_next_state != S_IDLE);
            r_frame_done    <= w_frame_inc;

            if (w_start) begin
                r_frame_count <= '0;
            end else if (w_frame_inc) begin
                r_frame_count <= w_count_inc;
            end

            if (w_start) begin
                r_stop_pending <= 1'b0;
            end else if (bus.cmdStop && (r_state != S_IDLE)) begin
                r_stop_pending <= 1'b1;
            end

            if (r_state == S_INIT) begin
                r_init_timer <= 8'(INIT_TIMEOUT - 1);
            end else if (r_state == S_WAIT_INIT) begin
                r_init_timer <= w_timer_dec;
            end

            // Set events beat a simultaneous clear.
            if (w_set_irq) begin
                r_irq <= 1'b1;
            end else if (bus.irqClear) begin
                r_irq <= 1'b0;
            end

            if (w_set_err) begin
                r_err_timeout <= 1'b1;
            end else if (bus.irqClear) begin
                r_err_timeout <= 1'b0;
            end
        end
    end

    assign bus.regCtrlInit = r_reg_ctrl_init;
    assign bus.regCtrlRun  = r_reg_ctrl_run;
    assign bus.initSlow    = r_init_slow;
    assign bus.busy        = r_busy;
    assign bus.frameDone   = r_frame_done;
    assign bus.frameCount  = r_frame_count;
    assign bus.irq         = r_irq;
    assign bus.errTimeout  = r_err_timeout;
    assign bus.seqState    = r_state;
endmodule

// File: tb/tb_anton_neopixel_frame_sequencer.sv
// Directed bench for the frame sequencer; frameDone pulses are checked
// against a queue of expected frame counts pushed when each sync is driven.
module tb_anton_neopixel_frame_sequencer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [7:0] exp_q[$];

    anton_neopixel_frame_sequencer_if #(.FRAME_BITS(8)) bus ();

    anton_neopixel_frame_sequencer #(
        .INIT_TIMEOUT(16),
        .FRAME_BITS(8)
    ) dut (
        .clk6_4mhz(clk),
        .resetn(resetn),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and look at registered outputs 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.frameDone === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_frameDone", {31'd0, bus.frameDone}, 32'd0);
            end else begin
                chk("frameCount_at_done", {24'd0, bus.frameCount}, {24'd0, exp_q.pop_front()});
            end
        end
    endtask

    task automatic start_run();
        bus.cmdStart = 1'b1;
        tick();
        bus.cmdStart = 1'b0;
        chk("init_state", {29'd0, bus.seqState}, 32'd1);
        chk("initSlow_high", {31'd0, bus.initSlow}, 32'd1);
        tick();
        chk("wait_state", {29'd0, bus.seqState}, 32'd2);
        chk("initSlow_one_cycle", {31'd0, bus.initSlow}, 32'd0);
    endtask

    task automatic ack();
        bus.initSlowDone = 1'b1;
        tick();
        bus.initSlowDone = 1'b0;
        chk("ack_run", {31'd0, bus.regCtrlRun}, 32'd1);
        chk("ack_stream", {29'd0, bus.seqState}, 32'd3);
    endtask

    task automatic frame(input logic [7:0] exp_cnt, input logic [2:0] exp_state,
                         input logic stop_now, input logic clr);
        bus.streamPixelOf = 1'b1;
        tick();
        bus.streamPixelOf = 1'b0;
        chk("gap_state", {29'd0, bus.seqState}, 32'd4);
        chk("gap_run", {31'd0, bus.regCtrlRun}, 32'd1);
        tick();
        bus.streamSyncOf = 1'b1;
        bus.cmdStop      = stop_now;
        bus.irqClear     = clr;
        exp_q.push_back(exp_cnt);
        tick();
        bus.streamSyncOf = 1'b0;
        bus.cmdStop      = 1'b0;
        bus.irqClear     = 1'b0;
        chk("frameDone_seen", exp_q.size(), 32'd0);
        chk("post_sync_state", {29'd0, bus.seqState}, {29'd0, exp_state});
        chk("post_sync_run", {31'd0, bus.regCtrlRun}, (exp_state == 3'd3) ? 32'd1 : 32'd0);
    endtask

    task automatic clear_irq();
        bus.irqClear = 1'b1;
        tick();
        bus.irqClear = 1'b0;
        chk("irq_cleared", {31'd0, bus.irq}, 32'd0);
        chk("err_cleared", {31'd0, bus.errTimeout}, 32'd0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, {29'd0, bus.seqState}, 32'd0);
        chk({tag, "_init"}, {31'd0, bus.regCtrlInit}, 32'd1);
        chk({tag, "_run"}, {31'd0, bus.regCtrlRun}, 32'd0);
        chk({tag, "_initSlow"}, {31'd0, bus.initSlow}, 32'd0);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, "_frameDone"}, {31'd0, bus.frameDone}, 32'd0);
        chk({tag, "_count"}, {24'd0, bus.frameCount}, 32'd0);
        chk({tag, "_irq"}, {31'd0, bus.irq}, 32'd0);
        chk({tag, "_err"}, {31'd0, bus.errTimeout}, 32'd0);
    endtask

    initial begin
        bus.cmdStart = 1'b0; bus.cmdStop = 1'b0; bus.cmdAbort = 1'b0;
        bus.cfgLoop = 1'b0; bus.cfgFrameLimit = 8'd0; bus.irqClear = 1'b0;
        bus.streamPixelOf = 1'b0; bus.streamSyncOf = 1'b0; bus.initSlowDone = 1'b0;

        tick();
        tick();
        chk_reset_values("reset");
        resetn = 1'b1;

        // Single frame.
        start_run();
        ack();
        frame(8'd1, 3'd0, 1'b0, 1'b0);
        chk("single_count", {24'd0, bus.frameCount}, 32'd1);
        chk("single_irq", {31'd0, bus.irq}, 32'd1);
        chk("single_init", {31'd0, bus.regCtrlInit}, 32'd1);
        chk("single_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("single_done_pulse", {31'd0, bus.frameDone}, 32'd0);

        // Loop with limit 3; last sync also carries irqClear (set must win).
        clear_irq();
        bus.cfgLoop = 1'b1;
        bus.cfgFrameLimit = 8'd3;
        start_run();
        ack();
        frame(8'd1, 3'd3, 1'b0, 1'b0);
        frame(8'd2, 3'd3, 1'b0, 1'b0);
        chk("loop_irq_mid", {31'd0, bus.irq}, 32'd0);
        frame(8'd3, 3'd0, 1'b0, 1'b1);
        chk("loop_count", {24'd0, bus.frameCount}, 32'd3);
        chk("loop_irq", {31'd0, bus.irq}, 32'd1);

        // Graceful stop during frame 2's STREAM, unlimited frames.
        clear_irq();
        bus.cfgFrameLimit = 8'd0;
        start_run();
        ack();
        frame(8'd1, 3'd3, 1'b0, 1'b0);
        bus.cmdStop = 1'b1;
        tick();
        bus.cmdStop = 1'b0;
        chk("stop_still_stream", {29'd0, bus.seqState}, 32'd3);
        frame(8'd2, 3'd0, 1'b0, 1'b0);
        chk("stop_count", {24'd0, bus.frameCount}, 32'd2);
        chk("stop_irq", {31'd0, bus.irq}, 32'd1);

        // Stop coinciding with frame 1's sync.
        clear_irq();
        start_run();
        ack();
        frame(8'd1, 3'd0, 1'b1, 1'b0);
        chk("stopsync_count", {24'd0, bus.frameCount}, 32'd1);
        chk("stopsync_irq", {31'd0, bus.irq}, 32'd1);

        // Reset while in GAP (irq still set from the previous run).
        start_run();
        ack();
        bus.streamPixelOf = 1'b1;
        tick();
        bus.streamPixelOf = 1'b0;
        chk("rst_gap_state", {29'd0, bus.seqState}, 32'd4);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk_reset_values("midrst");
        bus.streamSyncOf = 1'b1;
        tick();
        bus.streamSyncOf = 1'b0;
        chk("midrst_sync_nodone", {31'd0, bus.frameDone}, 32'd0);
        chk("midrst_sync_state", {29'd0, bus.seqState}, 32'd0);

        // Abort during STREAM, then restart.
        start_run();
        ack();
        bus.cmdAbort = 1'b1;
        tick();
        bus.cmdAbort = 1'b0;
        chk("abort_state", {29'd0, bus.seqState}, 32'd0);
        chk("abort_run", {31'd0, bus.regCtrlRun}, 32'd0);
        chk("abort_init", {31'd0, bus.regCtrlInit}, 32'd1);
        chk("abort_irq", {31'd0, bus.irq}, 32'd0);
        chk("abort_frameDone", {31'd0, bus.frameDone}, 32'd0);
        start_run();
        ack();

        // Abort together with sync: no frameDone, no increment.
        bus.streamPixelOf = 1'b1;
        tick();
        bus.streamPixelOf = 1'b0;
        tick();
        bus.streamSyncOf = 1'b1;
        bus.cmdAbort = 1'b1;
        tick();
        bus.streamSyncOf = 1'b0;
        bus.cmdAbort = 1'b0;
        chk("abortsync_frameDone", {31'd0, bus.frameDone}, 32'd0);
        chk("abortsync_count", {24'd0, bus.frameCount}, 32'd0);
        chk("abortsync_irq", {31'd0, bus.irq}, 32'd0);
        chk("abortsync_state", {29'd0, bus.seqState}, 32'd0);

        // Init timeout: error exactly 16 cycles after the INIT cycle.
        bus.cmdStart = 1'b1;
        tick();
        bus.cmdStart = 1'b0;
        chk("to_init", {31'd0, bus.initSlow}, 32'd1);
        for (int i = 0; i < 15; i++) tick();
        chk("to_not_yet", {31'd0, bus.errTimeout}, 32'd0);
        chk("to_wait_state", {29'd0, bus.seqState}, 32'd2);
        tick();
        chk("to_err", {31'd0, bus.errTimeout}, 32'd1);
        chk("to_irq", {31'd0, bus.irq}, 32'd1);
        chk("to_state", {29'd0, bus.seqState}, 32'd0);
        clear_irq();

        // Done on the final count cycle wins over timeout.
        bus.cmdStart = 1'b1;
        tick();
        bus.cmdStart = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        bus.initSlowDone = 1'b1;
        tick();
        bus.initSlowDone = 1'b0;
        chk("lastack_err", {31'd0, bus.errTimeout}, 32'd0);
        chk("lastack_state", {29'd0, bus.seqState}, 32'd3);
        bus.cmdAbort = 1'b1;
        tick();
        bus.cmdAbort = 1'b0;
        chk("lastack_abort_state", {29'd0, bus.seqState}, 32'd0);
        chk("sb_empty_end", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
